// File: rtl/aes_stream_loader.sv
// Byte-serial key/block loader and cipher streamer for a combinational
// AES-256 core: header-framed input, fixed settle, byte-wise output.
module aes_stream_loader #(
  parameter int nk     = 8,
  parameter int nb     = 4,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [32*nk-1:0]  key,
  output logic [32*nb-1:0]  msg,
  input  logic [32*nb-1:0]  cipher_in,
  input  logic [32*nb-1:0]  plain_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              match,
  output logic              err
);

  localparam int KB   = 4 * nk;
  localparam int MB   = 4 * nb;
  localparam int MAXB = (KB > MB) ? KB : MB;
  localparam int CW   = $clog2(MAXB);
  localparam int SW   = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LKEY,
    S_LMSG,
    S_WAIT,
    S_SEND
  } st_t;

  st_t              r_st;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_scnt;
  logic [32*nk-1:0] r_key;
  logic [32*nb-1:0] r_msg;
  logic [32*nb-1:0] r_cbuf;
  logic             r_kl;
  logic             r_match;
  logic             r_err;
  logic [CW-1:0]    w_slot;
  logic [7:0]       w_odata;

  // Byte i lands in slot i^3: big-endian bytes within little-endian words
  assign w_slot = r_cnt ^ CW'(3);

  assign in_ready  = (r_st == S_IDLE) || (r_st == S_LKEY) ||
                     (r_st == S_LMSG);
  assign out_valid = (r_st == S_SEND);
  assign out_last  = (r_st == S_SEND) && (r_cnt == CW'(MB - 1));
  assign out_data  = w_odata;
  assign key       = r_key;
  assign msg       = r_msg;
  assign match     = r_match;
  assign err       = r_err;

  always_comb begin
    w_odata = '0;
    if (r_st == S_SEND) begin
      for (int b = 0; b < MB; b++) begin
        if (w_slot == CW'(b)) w_odata = r_cbuf[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= S_IDLE;
      r_cnt   <= '0;
      r_scnt  <= '0;
      r_key   <= '0;
      r_msg   <= '0;
      r_cbuf  <= '0;
      r_kl    <= 1'b0;
      r_match <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_st)
        S_IDLE: begin
          if (in_valid) begin
            if (in_data == 8'h4B) begin
              r_st  <= S_LKEY;
              r_cnt <= '0;
            end else if (in_data == 8'h4D && r_kl) begin
              r_st  <= S_LMSG;
              r_cnt <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LKEY: begin
          if (in_valid) begin
            for (int b = 0; b < KB; b++) begin
              if (w_slot == CW'(b)) r_key[8*b +: 8] <= in_data;
            end
            if (r_cnt == CW'(KB - 1)) begin
              r_kl  <= 1'b1;
              r_st  <= S_IDLE;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_LMSG: begin
          if (in_valid) begin
            for (int b = 0; b < MB; b++) begin
              if (w_slot == CW'(b)) r_msg[8*b +: 8] <= in_data;
            end
            if (r_cnt == CW'(MB - 1)) begin
              r_st   <= S_WAIT;
              r_cnt  <= '0;
              r_scnt <= SW'(SETTLE);
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_WAIT: begin
          if (r_scnt == '0) begin
            r_cbuf  <= cipher_in;
            r_match <= (plain_in == r_msg);
            r_st    <= S_SEND;
            r_cnt   <= '0;
          end else begin
            r_scnt <= r_scnt - SW'(1);
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (r_cnt == CW'(MB - 1)) begin
              r_st  <= S_IDLE;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Randomized bench for aes_stream_loader with a stand-in AES core and a
// byte-array reference model of loading, timing and streaming.
module tb_aes_stream_loader;

  localparam int NK = 8;
  localparam int NB = 4;
  localparam int ST = 4;
  localparam int KB = 4 * NK;
  localparam int MB = 4 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] key;
  logic [127:0] msg;
  logic [127:0] cipher_in;
  logic [127:0] plain_in;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         match;
  logic         err;

  logic         corrupt = 1'b0;
  int           n_chk = 0;
  int           n_fail = 0;
  byte unsigned kb[KB];
  byte unsigned mb[MB];
  byte unsigned fb[MB];
  logic [255:0] fkey = '1;
  logic [127:0] fpt = '1;
  logic [127:0] fct = '0;

  always #5 clk = ~clk;

  aes_stream_loader #(.nk(NK), .nb(NB), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .msg(msg),
    .cipher_in(cipher_in), .plain_in(plain_in),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .match(match), .err(err)
  );

  function automatic logic [127:0] core(input logic [255:0] k,
                                        input logic [127:0] m);
    return m ^ k[127:0] ^ {k[191:128], k[255:192]} ^
           128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  // Stand-in core: FIPS-197 C.3 answer for its vector, a keyed mix otherwise
  always_comb begin
    cipher_in = (key == fkey && msg == fpt) ? fct : core(key, msg);
    plain_in  = msg ^ {127'b0, corrupt};
  end

  function automatic logic [255:0] kvec();
    logic [255:0] v = '0;
    for (int i = 0; i < KB; i++) v[32*(i/4) + 8*(3 - i%4) +: 8] = kb[i];
    return v;
  endfunction

  function automatic logic [127:0] mvec();
    logic [127:0] v = '0;
    for (int i = 0; i < MB; i++) v[32*(i/4) + 8*(3 - i%4) +: 8] = mb[i];
    return v;
  endfunction

  function automatic logic [7:0] cbyte(input logic [127:0] c, input int j);
    return c[32*(j/4) + 8*(3 - j%4) +: 8];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit hold, output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      if (hold) begin
        in_data  = 8'h4B;
        in_valid = 1'b1;
        chk("ign_rdy", in_ready, 0);
        chk("ign_err", err, 0);
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic recv(input bit rnd, input bit hold,
                      input logic [127:0] c, output int cyc);
    int got = 0;
    bit stalled = 1'b0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    cyc = 0;
    while (got < MB && cyc < 2000) begin
      if (stalled) begin
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
      end
      out_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      if (hold) begin
        chk("ign_rdy", in_ready, 0);
        chk("ign_err", err, 0);
        in_data  = 8'h4B;
        in_valid = !(out_last && out_ready);
      end
      if (out_valid && out_ready) begin
        chk("out_byte", out_data, cbyte(c, got));
        chk("out_last", out_last, got == MB - 1);
        got++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        pd = out_data;
        pl = out_last;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("recv_count", got, MB);
    chk("idle_rdy", in_ready, 1);
    chk("idle_valid", out_valid, 0);
  endtask

  task automatic load_key();
    put(8'h4B);
    chk("hdr_k_err", err, 0);
    for (int i = 0; i < KB; i++) put(kb[i]);
    chk("key", key, kvec());
  endtask

  task automatic load_msg();
    put(8'h4D);
    chk("hdr_m_err", err, 0);
    for (int i = 0; i < MB; i++) put(mb[i]);
    chk("msg", msg, mvec());
    chk("key_held", key, kvec());
  endtask

  task automatic run_block(input bit rnd, input bit hold,
                           input logic [127:0] c);
    int n;
    int cyc;
    load_msg();
    wait_valid(hold, n);
    chk("settle", n, ST + 1);
    recv(rnd, hold, c, cyc);
    if (!rnd) chk("send_cycles", cyc, MB);
    chk("match", match, !corrupt);
    chk("key_kept", key, kvec());
  endtask

  initial begin
    int n;
    logic [127:0] ec;
    for (int i = 0; i < KB; i++) kb[i] = byte'(i);
    for (int i = 0; i < MB; i++) mb[i] = byte'(i * 8'h11);
    fb = '{8'h8e, 8'ha2, 8'hb7, 8'hca, 8'h51, 8'h67, 8'h45, 8'hbf,
           8'hea, 8'hfc, 8'h49, 8'h90, 8'h4b, 8'h49, 8'h60, 8'h89};
    for (int i = 0; i < MB; i++) fct[32*(i/4) + 8*(3 - i%4) +: 8] = fb[i];
    fkey = kvec();
    fpt  = mvec();

    #12;
    chk("rst_key", key, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_match", match, 0);

    put(8'h00);
    chk("bad00_err", err, 1);
    @(posedge clk);
    #1;
    chk("bad00_pulse", err, 0);
    put(8'h4D);
    chk("bad4d_err", err, 1);
    @(posedge clk);
    #1;
    chk("bad4d_pulse", err, 0);
    chk("bad_key", key, 0);
    chk("bad_rdy", in_ready, 1);

    load_key();
    run_block(1'b0, 1'b0, fct);
    run_block(1'b0, 1'b1, fct);

    for (int i = 0; i < KB; i++) kb[i] = byte'($urandom);
    load_key();
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < MB; i++) mb[i] = byte'($urandom);
      corrupt = 1'($urandom_range(1));
      ec = core(kvec(), mvec());
      run_block(1'b1, t[0], ec);
    end
    corrupt = 1'b0;

    for (int i = 0; i < MB; i++) mb[i] = byte'($urandom);
    load_msg();
    wait_valid(1'b0, n);
    chk("settle_r", n, ST + 1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_data", out_data, 0);
    chk("mid_last", out_last, 0);
    chk("mid_key", key, 0);
    chk("mid_msg", msg, 0);
    chk("mid_match", match, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rdy", in_ready, 1);
    put(8'h4D);
    chk("mid_4d_err", err, 1);
    chk("mid_4d_key", key, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
